// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes and arbiter FSM encoding
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master_arbiter_if.sv
// rtl/axi_lite_master_arbiter_if.sv - AXI-Lite AW/W/B/AR/R channel bundle
interface axi_lite_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin arbiter with last-grant pointer
module rr_arbiter_2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);
    logic last_q;
    logic last_d;

    // Grant the single requester, or the one not served last when contested
    always_comb begin
        o_gnt  = 2'b00;
        last_d = last_q;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
            if (o_gnt != 2'b00) begin
                last_d = o_gnt[1];
            end
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contest
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - shares one AXI-Lite master port between two requesters
module axi_lite_master_arbiter
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_axi_clk,
    input  logic                  i_axi_rst,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic                  i_req0_write,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [31:0]           i_req0_wdata,
    input  logic [3:0]            i_req0_wstrb,
    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic [31:0]           o_rsp0_data,
    output logic [1:0]            o_rsp0_resp,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic                  i_req1_write,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [31:0]           i_req1_wdata,
    input  logic [3:0]            i_req1_wstrb,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [31:0]           o_rsp1_data,
    output logic [1:0]            o_rsp1_resp,
    axi_lite_master_arbiter_if.master m_axi
);
    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;
    logic [1:0]            gnt;
    logic                  arb_en;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  rsp_ready;

    // Arbitration only happens from IDLE; reset masks any grant pulse
    assign arb_en = (state_q == ST_IDLE) && !i_axi_rst;

    rr_arbiter_2 u_arb (
        .i_clk (i_axi_clk),
        .i_rst (i_axi_rst),
        .i_req ({i_req1_valid, i_req0_valid}),
        .i_en  (arb_en),
        .o_gnt (gnt)
    );

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];

    // AXI outputs depend only on registered state, never on AXI inputs
    assign m_axi.awvalid = (state_q == ST_WRITE) && !aw_done_q;
    assign m_axi.wvalid  = (state_q == ST_WRITE) && !w_done_q;
    assign m_axi.bready  = (state_q == ST_WRESP);
    assign m_axi.arvalid = (state_q == ST_READ);
    assign m_axi.rready  = (state_q == ST_RDATA);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;

    assign aw_hs     = m_axi.awvalid && m_axi.awready;
    assign w_hs      = m_axi.wvalid && m_axi.wready;
    assign rsp_ready = owner_q ? i_rsp1_ready : i_rsp0_ready;

    assign o_rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign o_rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign o_rsp0_data  = rdata_q;
    assign o_rsp1_data  = rdata_q;
    assign o_rsp0_resp  = resp_q;
    assign o_rsp1_resp  = resp_q;

    // Next-state logic: latch the winner's command, walk the AXI channels, return response
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d   = gnt[1];
                    addr_d    = gnt[1] ? i_req1_addr  : i_req0_addr;
                    wdata_d   = gnt[1] ? i_req1_wdata : i_req0_wdata;
                    wstrb_d   = gnt[1] ? i_req1_wstrb : i_req0_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (gnt[1] ? i_req1_write : i_req0_write) ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end
            end
            ST_READ: begin
                if (m_axi.arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (m_axi.rvalid) begin
                    rdata_d = m_axi.rdata;
                    resp_d  = m_axi.rresp;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= 32'd0;
            resp_q    <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - randomized bench with slave model and scoreboard
module tb_axi_lite_master_arbiter;

    typedef struct {
        int          owner;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    logic        r_valid   [2];
    logic        r_write   [2];
    logic [31:0] r_addr    [2];
    logic [31:0] r_wdata   [2];
    logic [3:0]  r_wstrb   [2];
    logic        rsp_ready [2];
    logic        o_req0_ready, o_req1_ready;
    logic        o_rsp0_valid, o_rsp1_valid;
    logic [31:0] o_rsp0_data, o_rsp1_data;
    logic [1:0]  o_rsp0_resp, o_rsp1_resp;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // reference model state (monitor)
    logic [31:0] ref_mem [16];
    exp_t        exp_q [$];
    int          gnt_log [$];
    bit          busy = 0;
    int          last_gnt = 1;
    bit          gnt_flag [2];
    int          m_win;
    int          m_own;
    exp_t        m_e;

    // slave model state
    logic [31:0] slave_mem [16];
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit b_early = 0;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit aw_got, w_got, b_fire, ar_got, r_fire;
    logic [31:0] s_addr, s_wdata, s_raddr;
    logic [3:0]  s_wstrb;

    axi_lite_master_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    axi_lite_master_arbiter #(.ADDR_WIDTH(32)) dut (
        .i_axi_clk    (clk),
        .i_axi_rst    (rst),
        .i_req0_valid (r_valid[0]),
        .o_req0_ready (o_req0_ready),
        .i_req0_write (r_write[0]),
        .i_req0_addr  (r_addr[0]),
        .i_req0_wdata (r_wdata[0]),
        .i_req0_wstrb (r_wstrb[0]),
        .o_rsp0_valid (o_rsp0_valid),
        .i_rsp0_ready (rsp_ready[0]),
        .o_rsp0_data  (o_rsp0_data),
        .o_rsp0_resp  (o_rsp0_resp),
        .i_req1_valid (r_valid[1]),
        .o_req1_ready (o_req1_ready),
        .i_req1_write (r_write[1]),
        .i_req1_addr  (r_addr[1]),
        .i_req1_wdata (r_wdata[1]),
        .i_req1_wstrb (r_wstrb[1]),
        .o_rsp1_valid (o_rsp1_valid),
        .i_rsp1_ready (rsp_ready[1]),
        .o_rsp1_data  (o_rsp1_data),
        .o_rsp1_resp  (o_rsp1_resp),
        .m_axi        (bus)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: grant prediction and end-to-end response scoreboard
    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0;
                last_gnt = 1;
                exp_q.delete();
            end else begin
                m_win = -1;
                if (!busy && (r_valid[0] || r_valid[1])) begin
                    if (r_valid[0] && r_valid[1]) m_win = (last_gnt == 1) ? 0 : 1;
                    else m_win = r_valid[1] ? 1 : 0;
                end
                chk("gnt0", o_req0_ready, m_win == 0);
                chk("gnt1", o_req1_ready, m_win == 1);
                if (o_req0_ready) begin gnt_log.push_back(0); gnt_flag[0] = 1; end
                if (o_req1_ready) begin gnt_log.push_back(1); gnt_flag[1] = 1; end
                if (!busy) begin
                    chk("rsp0_valid_idle", o_rsp0_valid, 0);
                    chk("rsp1_valid_idle", o_rsp1_valid, 0);
                end else begin
                    m_own = exp_q[0].owner;
                    chk("rsp_nonowner", (m_own == 0) ? o_rsp1_valid : o_rsp0_valid, 0);
                    if (((m_own == 0) ? o_rsp0_valid : o_rsp1_valid) && rsp_ready[m_own]) begin
                        m_e = exp_q.pop_front();
                        chk("rsp_data", (m_own == 0) ? o_rsp0_data : o_rsp1_data, m_e.data);
                        chk("rsp_resp", (m_own == 0) ? o_rsp0_resp : o_rsp1_resp, {30'd0, m_e.resp});
                        busy = 0;
                    end
                end
                if (m_win >= 0) begin
                    m_e.owner = m_win;
                    m_e.resp  = r_addr[m_win][5:4];
                    if (r_write[m_win]) begin
                        m_e.data = 32'd0;
                        for (int b = 0; b < 4; b++)
                            if (r_wstrb[m_win][b])
                                ref_mem[r_addr[m_win][5:2]][8*b +: 8] = r_wdata[m_win][8*b +: 8];
                    end else begin
                        m_e.data = ref_mem[r_addr[m_win][5:2]];
                    end
                    exp_q.push_back(m_e);
                    busy = 1;
                    last_gnt = m_win;
                end
            end
        end
    end

    // Slave register bank: response code = addr[5:4], configurable wait states
    initial begin
        for (int i = 0; i < 16; i++) slave_mem[i] = 32'd0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                bus.arready = 0; bus.rvalid = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                aw_got = 0; w_got = 0; b_fire = 0; ar_got = 0; r_fire = 0;
            end else begin
                if (b_fire) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) slave_mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    bus.bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; b_fire = 0;
                end else if (aw_got && w_got && !bus.bvalid) begin
                    if (b_wait >= b_dly) begin bus.bvalid = 1; bus.bresp = s_addr[5:4]; end
                    else b_wait++;
                end else if (b_early && !bus.bvalid && bus.awvalid) begin
                    bus.bvalid = 1; bus.bresp = bus.awaddr[5:4];
                end
                if (bus.awvalid) begin
                    bus.awready = (aw_wait >= aw_dly);
                    if (bus.awready) begin aw_got = 1; s_addr = bus.awaddr; end
                    aw_wait++;
                end else begin bus.awready = 0; aw_wait = 0; end
                if (bus.wvalid) begin
                    bus.wready = (w_wait >= w_dly);
                    if (bus.wready) begin w_got = 1; s_wdata = bus.wdata; s_wstrb = bus.wstrb; end
                    w_wait++;
                end else begin bus.wready = 0; w_wait = 0; end
                if (bus.bvalid && bus.bready) b_fire = 1;
                if (r_fire) begin
                    bus.rvalid = 0; ar_got = 0; r_wait = 0; r_fire = 0;
                end else if (ar_got && !bus.rvalid) begin
                    if (r_wait >= r_dly) begin
                        bus.rvalid = 1; bus.rdata = slave_mem[s_raddr[5:2]]; bus.rresp = s_raddr[5:4];
                    end else r_wait++;
                end
                if (bus.arvalid) begin
                    bus.arready = (ar_wait >= ar_dly);
                    if (bus.arready) begin ar_got = 1; s_raddr = bus.araddr; end
                    ar_wait++;
                end else begin bus.arready = 0; ar_wait = 0; end
                if (bus.rvalid && bus.rready) r_fire = 1;
            end
        end
    end

    task automatic wait_grant(input int n, output int gc);
        gc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((n == 0) ? o_req0_ready : o_req1_ready) begin gc = cyc; break; end
            @(posedge clk); #1;
        end
        chk("grant_seen", gc >= 0, 1);
    endtask

    task automatic issue(input int n, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int gc);
        r_write[n] = wr; r_addr[n] = a; r_wdata[n] = d; r_wstrb[n] = s; r_valid[n] = 1;
        wait_grant(n, gc);
        @(posedge clk); #1;
        r_valid[n] = 0;
    endtask

    task automatic wait_rsp(input int n, input int gc, output int lat);
        bit seen;
        seen = 0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((n == 0) ? o_rsp0_valid : o_rsp1_valid) begin seen = 1; lat = cyc - gc; break; end
        end
        chk("rsp_seen", seen, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        chk("idle", busy, 0);
    endtask

    task automatic new_cmd(input int n);
        r_write[n] = ($urandom % 2 == 1);
        r_addr[n]  = {26'd0, 4'($urandom % 16), 2'b00};
        r_wdata[n] = $urandom;
        r_wstrb[n] = 4'($urandom % 16);
    endtask

    int gc, lat, acc, early_cycles;
    int exp_order [4] = '{0, 1, 0, 1};

    initial begin
        for (int n = 0; n < 2; n++) begin
            r_valid[n] = 0; r_write[n] = 0; r_addr[n] = 0; r_wdata[n] = 0; r_wstrb[n] = 0;
            rsp_ready[n] = 1; gnt_flag[n] = 0;
        end
        // reset: no grant even with a request pending
        r_valid[0] = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", o_req0_ready, 0);
        @(posedge clk); #1;
        r_valid[0] = 0; rst = 0;
        @(negedge clk);
        chk("rst_awvalid", bus.awvalid, 0);
        chk("rst_wvalid", bus.wvalid, 0);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_bready", bus.bready, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_rsp0_data", o_rsp0_data, 0);
        chk("rst_rsp1_resp", o_rsp1_resp, 0);
        @(posedge clk); #1;

        // contested round-robin from reset
        r_write[0] = 0; r_addr[0] = 32'h00; r_valid[0] = 1;
        r_write[1] = 0; r_addr[1] = 32'h10; r_valid[1] = 1;
        for (int i = 0; i < 200; i++) begin
            if (gnt_log.size() >= 4) break;
            @(posedge clk); #1;
        end
        r_valid[0] = 0; r_valid[1] = 0;
        chk("rr_count", gnt_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("rr_order", gnt_log[i], exp_order[i]);
        wait_idle();

        // single write then read-back, zero-wait slave
        issue(0, 1, 32'h04, 32'hDEADBEEF, 4'hF, gc);
        @(negedge clk);
        chk("wr_awvalid_c1", bus.awvalid, 1);
        chk("wr_wvalid_c1", bus.wvalid, 1);
        chk("wr_awaddr", bus.awaddr, 32'h04);
        chk("wr_wdata", bus.wdata, 32'hDEADBEEF);
        wait_rsp(0, gc, lat);
        chk("wr_latency", lat, 3);
        chk("wr_resp", o_rsp0_resp, 2'b00);
        wait_idle();
        issue(0, 0, 32'h04, 32'h0, 4'h0, gc);
        @(negedge clk);
        chk("rd_arvalid_c1", bus.arvalid, 1);
        chk("rd_araddr", bus.araddr, 32'h04);
        wait_rsp(0, gc, lat);
        chk("rd_latency", lat, 3);
        chk("rd_data", o_rsp0_data, 32'hDEADBEEF);
        wait_idle();

        // W accepted three cycles after AW
        aw_dly = 0; w_dly = 3;
        issue(0, 1, 32'h0C, 32'h0BADF00D, 4'hF, gc);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 2) begin chk("wdly_awvalid", bus.awvalid, 0); chk("wdly_wvalid2", bus.wvalid, 1); end
            if (k == 4) chk("wdly_wvalid4", bus.wvalid, 1);
            if (k == 5) begin chk("wdly_wvalid5", bus.wvalid, 0); chk("wdly_bready", bus.bready, 1); end
        end
        wait_rsp(0, gc, lat);
        chk("wdly_latency", lat, 6);
        w_dly = 0;
        wait_idle();

        // SLVERR read held by requester 1; no grant while held
        issue(1, 1, 32'h20, 32'h12345678, 4'hF, gc);
        wait_idle();
        rsp_ready[1] = 0;
        issue(1, 0, 32'h20, 32'h0, 4'h0, gc);
        wait_rsp(1, gc, lat);
        @(posedge clk); #1;
        r_write[0] = 0; r_addr[0] = 32'h00; r_valid[0] = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", o_rsp1_valid, 1);
            chk("hold_data", o_rsp1_data, 32'h12345678);
            chk("hold_resp", o_rsp1_resp, 2'b10);
            chk("hold_nogrant", o_req0_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready[1] = 1;
        @(negedge clk);
        acc = cyc;
        @(posedge clk); #1;
        wait_grant(0, gc);
        chk("b2b_grant", gc - acc, 1);
        @(posedge clk); #1;
        r_valid[0] = 0;
        wait_idle();

        // B offered early while still in WRITE must not be taken
        aw_dly = 2; w_dly = 2; b_early = 1; early_cycles = 0;
        issue(0, 1, 32'h08, 32'hA5A5A5A5, 4'h3, gc);
        for (int i = 0; i < 20; i++) begin
            if (o_rsp0_valid) break;
            if ((bus.awvalid || bus.wvalid) && bus.bvalid) begin
                chk("early_bready", bus.bready, 0);
                early_cycles++;
            end
            @(posedge clk); #1;
        end
        chk("early_latency", cyc - gc, 5);
        aw_dly = 0; w_dly = 0; b_early = 0;
        wait_idle();
        issue(0, 0, 32'h08, 32'h0, 4'h0, gc);
        wait_rsp(0, gc, lat);
        chk("strb_data", o_rsp0_data, 32'h0000A5A5);
        wait_idle();

        // reset while waiting in RDATA
        r_dly = 20;
        issue(0, 0, 32'h04, 32'h0, 4'h0, gc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rready) break;
        end
        chk("in_rdata", bus.rready, 1);
        @(posedge clk); #1;
        r_write[0] = 0; r_addr[0] = 32'h00; r_valid[0] = 1;
        r_write[1] = 0; r_addr[1] = 32'h10; r_valid[1] = 1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; r_dly = 0;
        @(negedge clk);
        chk("rrst_rready", bus.rready, 0);
        chk("rrst_arvalid", bus.arvalid, 0);
        chk("rrst_rsp0_valid", o_rsp0_valid, 0);
        chk("rrst_rsp0_data", o_rsp0_data, 0);
        chk("rrst_gnt0", o_req0_ready, 1);
        chk("rrst_gnt1", o_req1_ready, 0);
        @(posedge clk); #1;
        r_valid[0] = 0; r_valid[1] = 0;
        wait_idle();

        // randomized traffic against the scoreboard
        gnt_flag[0] = 0; gnt_flag[1] = 0;
        for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (gnt_flag[n]) begin
                    gnt_flag[n] = 0;
                    r_valid[n] = ($urandom % 2 == 1);
                    if (r_valid[n]) new_cmd(n);
                end else if (!r_valid[n] && ($urandom % 3 == 0)) begin
                    new_cmd(n);
                    r_valid[n] = 1;
                end
                rsp_ready[n] = ($urandom % 4 != 0);
            end
            aw_dly = $urandom % 3; w_dly = $urandom % 3; b_dly = $urandom % 3;
            ar_dly = $urandom % 3; r_dly = $urandom % 3;
        end
        r_valid[0] = 0; r_valid[1] = 0;
        rsp_ready[0] = 1; rsp_ready[1] = 1;
        wait_idle();
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/axi_lite_master_arbiter.md
# axi_lite_master_arbiter

Shares one AXI-Lite master port between two simple requesters (e.g. a host bridge and an on-chip sequencer) so both can reach a single `axi_lite_slave` register bank. Requests are granted round-robin, one transaction is in flight at a time, and each response is routed back to the requester that issued it. The block sits directly in front of the slave's AW/W/B/AR/R channels.

## Interface
- `ADDR_WIDTH`, 32, address width on requester and AXI sides.
- `i_axi_clk`  in  1  clock; all logic on rising edge.
- `i_axi_rst`  in  1  reset, synchronous, active-high.
- `i_reqN_valid`  in  1  requester N (N=0,1) command valid.
- `o_reqN_ready`  out  1  command accepted (grant pulse).
- `i_reqN_write`  in  1  1=write, 0=read.
- `i_reqN_addr`  in  ADDR_WIDTH  byte address.
- `i_reqN_wdata`  in  32  write data.
- `i_reqN_wstrb`  in  4  write strobes.
- `o_rspN_valid`  out  1  response valid to requester N.
- `i_rspN_ready`  in  1  requester N accepts response.
- `o_rspN_data`  out  32  read data (0 for writes).
- `o_rspN_resp`  out  2  AXI response code (BRESP or RRESP).
- `o_awvalid`/`i_awready`/`o_awaddr[ADDR_WIDTH]`, `o_wvalid`/`i_wready`/`o_wdata[32]`/`o_wstrb[4]`, `i_bvalid`/`o_bready`/`i_bresp[2]`, `o_arvalid`/`i_arready`/`o_araddr[ADDR_WIDTH]`, `i_rvalid`/`o_rready`/`i_rdata[32]`/`i_rresp[2]`: AXI-Lite master channels.

## Operation
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE: if any `i_reqN_valid`, arbiter picks winner; `o_reqN_ready` high for that requester for exactly this cycle; addr/wdata/wstrb/write and owner ID latched; next state WRITE or READ. No grant in any other state.
- Round-robin: if both valid, grant the requester not granted last; if one valid, grant it. Last-grant pointer resets to 1, so requester 0 wins the first contested arbitration.
- WRITE: `o_awvalid` and `o_wvalid` asserted together; each drops the cycle after its own handshake; AW and W may complete in either order or in the same cycle. When both done → WRESP.
- WRESP: `o_bready`=1; on `i_bvalid` latch `i_bresp`, data=0 → RESP.
- READ: `o_arvalid`=1 until `i_arready` → RDATA.
- RDATA: `o_rready`=1; on `i_rvalid` latch `i_rdata`, `i_rresp` → RESP.
- RESP: `o_rspN_valid`=1 for owner only; data/resp held stable; on `i_rspN_ready` → IDLE. Non-owner `o_rsp*_valid`=0.
- AXI address/data outputs are driven only from latched registers; they are stable while the corresponding valid is high.
- Response codes are passed through unmodified (SLVERR/DECERR are not interpreted).

## Timing
- Reset: state=IDLE, all `o_*valid`=0, `o_bready`=`o_rready`=0, `o_reqN_ready`=0, response data/resp=0, last-grant=1. Reset mid-transaction abandons it immediately; no response is issued.
- Grant: `o_reqN_ready` combinational from IDLE and `i_reqN_valid` (same cycle).
- Minimum write latency (zero-wait slave): grant cycle C, AW/W valid C+1, `i_bvalid` earliest C+2, `o_rsp_valid` C+3. Read: AR C+1, R earliest C+2, rsp C+3.
- Back-to-back: response accepted in cycle R → IDLE at R+1 → next grant possible at R+1.
- AXI valids never drop before handshake; no combinational path from AXI inputs to AXI valid outputs.

## Structure
- Shared package `axi_lite_pkg`: response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the FSM state encoding.
- Sub-module `rr_arbiter_2`: two request inputs, enable, one-hot grant output, last-grant pointer register updated on enable.

## Test plan
- Single write from req0, addr 0x04, data 0xDEADBEEF, strb 0xF, zero-wait slave → AW/W at C+1, `o_rsp0_valid` at C+3 with resp 0; subsequent req0 read of 0x04 returns data 0xDEADBEEF.
- Both requesters valid continuously, four transactions → grants in order 0,1,0,1; each response appears only on the owner's port.
- Slave asserts `i_wready` 3 cycles after `i_awready` → `o_awvalid` drops after AW handshake, `o_wvalid` held until W handshake, then WRESP.
- Slave returns `i_rresp`=2'b10, `i_rdata`=0x12345678 → `o_rsp1_resp`=2'b10, data=0x12345678; `i_rsp1_ready` held low 5 cycles → response stable, no new grant.
- `i_axi_rst` asserted while in RDATA → next cycle all valids/readies 0, state IDLE; next contested request granted to req0.
- `i_bvalid` asserted while `o_bready` low (in WRITE) is not consumed; response only taken in WRESP.
